// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_scan_ctrl
//  Brief    : Scans a message in data memory for a 5-bit pattern and writes
//             three match counts (in-byte, bytes-with-match, stream) back.
//  Revision : 1.0  initial release
// ============================================================================
module pattern_scan_ctrl #(
  parameter int AW        = 8,
  parameter int MSG_BASE  = 0,
  parameter int NUM_BYTES = 32,
  parameter int PAT_ADDR  = 32,
  parameter int RES_ADDR  = 33
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  localparam int              c_IW   = $clog2(NUM_BYTES);
  localparam logic [c_IW-1:0] c_LAST = c_IW'(NUM_BYTES - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_RD_PAT = 3'd1;
  localparam logic [2:0] c_SCAN   = 3'd2;
  localparam logic [2:0] c_WR_B   = 3'd3;
  localparam logic [2:0] c_WR_O   = 3'd4;
  localparam logic [2:0] c_WR_S   = 3'd5;
  localparam logic [2:0] c_FIN    = 3'd6;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [4:0]      r_pat;
  logic [3:0]      r_prev_lo;   // only the low nibble of the previous byte feeds crossing windows
  logic [c_IW-1:0] r_idx;
  logic [7:0]      r_ctb;
  logic [7:0]      r_cto;
  logic [7:0]      r_cts;
  logic            r_done;

  logic [11:0]     w_word;
  logic [7:0]      w_hit;
  logic [2:0]      w_inb;
  logic [2:0]      w_cross;
  logic            w_start;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Stream word: previous byte's low nibble followed by the current byte
  // (MSB-first stream, so earlier bits sit at higher positions).
  assign w_word = {r_prev_lo, mem_rd_data};

  // Windows 0..3 lie inside the current byte, 4..7 straddle the byte boundary.
  for (genvar j = 0; j < 8; j++) begin : g_win
    assign w_hit[j] = (w_word[j+4:j] == r_pat);
  end

  assign w_inb   = pop4(w_hit[3:0]);
  // Byte 0 has no predecessor, so its crossing windows do not exist.
  assign w_cross = (r_idx != '0) ? pop4(w_hit[7:4]) : 3'd0;

  assign w_start = ((r_state == c_IDLE) || (r_state == c_FIN)) && req;
  assign done    = r_done;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; requests are only honoured from IDLE or FIN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE, c_FIN: if (req) w_next = c_RD_PAT;
      c_RD_PAT:      w_next = c_SCAN;
      c_SCAN:        if (r_idx == c_LAST) w_next = c_WR_B;
      c_WR_B:        w_next = c_WR_O;
      c_WR_O:        w_next = c_WR_S;
      c_WR_S:        w_next = c_FIN;
      default:       w_next = c_IDLE;
    endcase
  end

  // Memory-side outputs decoded from the current state.
  always_comb begin
    busy        = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    case (r_state)
      c_RD_PAT: begin
        busy     = 1'b1;
        mem_addr = AW'(PAT_ADDR);
      end
      c_SCAN: begin
        busy     = 1'b1;
        mem_addr = AW'(MSG_BASE) + AW'(r_idx);
      end
      c_WR_B: begin
        busy        = 1'b1;
        mem_addr    = AW'(RES_ADDR);
        mem_wr_en   = 1'b1;
        mem_wr_data = r_ctb;
      end
      c_WR_O: begin
        busy        = 1'b1;
        mem_addr    = AW'(RES_ADDR + 1);
        mem_wr_en   = 1'b1;
        mem_wr_data = r_cto;
      end
      c_WR_S: begin
        busy        = 1'b1;
        mem_addr    = AW'(RES_ADDR + 2);
        mem_wr_en   = 1'b1;
        mem_wr_data = r_cts;
      end
      default: ;
    endcase
  end

  // Pattern latch and match counters; cleared at the start of every job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat     <= '0;
      r_prev_lo <= '0;
      r_idx     <= '0;
      r_ctb     <= '0;
      r_cto     <= '0;
      r_cts     <= '0;
    end else begin
      case (r_state)
        c_RD_PAT: begin
          r_pat     <= mem_rd_data[4:0];
          r_prev_lo <= '0;
          r_idx     <= '0;
          r_ctb     <= '0;
          r_cto     <= '0;
          r_cts     <= '0;
        end
        c_SCAN: begin
          r_ctb     <= r_ctb + {5'b0, w_inb};
          r_cto     <= r_cto + {7'b0, |w_hit[3:0]};
          r_cts     <= r_cts + {5'b0, w_inb} + {5'b0, w_cross};
          r_prev_lo <= mem_rd_data[3:0];
          r_idx     <= r_idx + c_IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Completion flag: cleared when a job is accepted, raised once FIN is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_done <= 1'b0;
    else if (w_start)           r_done <= 1'b0;
    else if (r_state == c_FIN)  r_done <= 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pattern_scan_ctrl
//  Brief    : Directed, table-driven bench for pattern_scan_ctrl with a
//             behavioural data memory and write logger.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:255];
  logic [7:0] res [0:2];
  int         wr_cnt = 0;
  int         bad_wr = 0;

  typedef struct {
    logic [7:0] fill;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] pat;
    int         ctb;
    int         cto;
    int         cts;
  } vec_t;

  vec_t tv [6];

  pattern_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  always #5 clk = ~clk;

  // Combinational read port; writes are captured into a result log.
  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      if (mem_addr >= 8'd33 && mem_addr <= 8'd35) res[int'(mem_addr) - 33] <= mem_wr_data;
      else bad_wr <= bad_wr + 1;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_msg(input logic [7:0] fill, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] pat);
    for (int i = 0; i < 32; i++) mem[i] = fill;
    mem[0]  = b0;
    mem[1]  = b1;
    mem[32] = pat;
  endtask

  // Returns #1 after the edge that samples req.
  task automatic start_job();
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  // Counts edges after the sampling edge until done reads high (bounded).
  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_results(input string tag, input int ctb, input int cto, input int cts);
    chk({tag, " ctb"}, int'(res[0]), ctb);
    chk({tag, " cto"}, int'(res[1]), cto);
    chk({tag, " cts"}, int'(res[2]), cts);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int w0;
    int cyc;
    fill_msg(v.fill, v.b0, v.b1, v.pat);
    w0 = wr_cnt;
    start_job();
    chk({tag, " busy after req"}, int'(busy), 1);
    chk({tag, " done cleared"}, int'(done), 0);
    chk({tag, " pat addr"}, int'(mem_addr), 32);
    wait_done(0, cyc);
    chk({tag, " latency"}, cyc, 37);
    chk({tag, " writes"}, wr_cnt - w0, 3);
    check_results(tag, v.ctb, v.cto, v.cts);
  endtask

  initial begin
    int w0;
    int cyc;

    tv[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 128, 32, 252};
    tv[1] = '{8'h55, 8'h55, 8'h55, 8'h15,  64, 32, 126};
    tv[2] = '{8'h00, 8'h03, 8'hE0, 8'h1F,   0,  0,   1};
    tv[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 128, 32, 252};
    tv[4] = '{8'hF0, 8'hF0, 8'hF0, 8'h1E,  32, 32,  32};
    tv[5] = '{8'h0F, 8'h0F, 8'h0F, 8'h1E,   0,  0,  31};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    res[0] = 8'h00; res[1] = 8'h00; res[2] = 8'h00;

    // Reset state.
    reset = 1'b1;
    req   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset done",     int'(done),        0);
    chk("reset busy",     int'(busy),        0);
    chk("reset wr_en",    int'(mem_wr_en),   0);
    chk("reset addr",     int'(mem_addr),    0);
    chk("reset wr_data",  int'(mem_wr_data), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle busy", int'(busy), 0);

    // Table-driven jobs.
    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tv[i]);

    // Reset during SCAN byte 10: nothing written, then a clean job.
    fill_msg(8'h00, 8'h00, 8'h00, 8'h00);
    w0 = wr_cnt;
    start_job();
    repeat (11) @(posedge clk);
    #1;
    chk("abort scan addr", int'(mem_addr), 10);
    reset = 1'b1;
    #1;
    chk("abort busy",  int'(busy),      0);
    chk("abort addr",  int'(mem_addr),  0);
    chk("abort wr_en", int'(mem_wr_en), 0);
    chk("abort done",  int'(done),      0);
    @(posedge clk); #1 reset = 1'b0;
    chk("abort no writes", wr_cnt - w0, 0);
    run_vec("post-abort", tv[0]);

    // req pulsed mid-SCAN is ignored; latency unchanged.
    fill_msg(8'h55, 8'h55, 8'h55, 8'h15);
    w0 = wr_cnt;
    start_job();
    repeat (5) @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    wait_done(6, cyc);
    chk("ignored req latency", cyc, 37);
    chk("ignored req writes",  wr_cnt - w0, 3);
    check_results("ignored req", 64, 32, 126);
    repeat (3) @(posedge clk);
    #1;
    chk("done held", int'(done), 1);
    chk("idle after fin", int'(busy), 0);

    // Back-to-back job with a new pattern: fresh counts.
    run_vec("second job", '{8'h00, 8'h00, 8'h00, 8'h01, 0, 0, 0});

    chk("stray writes", bad_wr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
